pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and instruction-fetch controller; next generation of the core PC register.
- Sits at the front of the pipeline, between the redirect sources (ID/EX/exception unit) and the instruction-memory bus.
- Adds a req/ack fetch handshake with wait states, a prioritised redirect mux, a pending-redirect latch for redirects arriving during an outstanding fetch, and target-alignment checking with an alignment-exception vector.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_VEC, 32'h80000000, PC value after reset.
- EXC_VEC, 32'h80000380, exception entry address; also used for alignment faults.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline stall; blocks new fetch issue
- exc_valid  in  1  exception redirect pulse
- exc_target  in  ADDR_W  exception handler address
- br_valid  in  1  taken conditional branch pulse
- br_target  in  ADDR_W  branch target
- jr_valid  in  1  jump-register pulse
- jr_target  in  ADDR_W  R[rs] value
- j_valid  in  1  direct jump pulse
- j_target  in  ADDR_W  jump target
- if_req  out  1  fetch request
- if_addr  out  ADDR_W  fetch address
- if_ack  in  1  fetch accepted/data returned this cycle
- inst_valid  out  1  acked fetch is on the correct path
- inst_pc  out  ADDR_W  address of the acked fetch (= if_addr)
- pc_plus4  out  ADDR_W  pc + 4
- align_err  out  1  one-cycle pulse: misaligned redirect target
- bad_vaddr  out  ADDR_W  last misaligned target

Behaviour:
- Reset values (asynchronous):
  - state = BOOT, pc = RESET_VEC, if_req = 0, inst_valid = 0.
  - pend_valid = 0, pend_is_exc = 0, align_err = 0, bad_vaddr = 0.
- States:
  - BOOT: one dead cycle after reset release, always followed by IDLE.
  - IDLE: if_req = 0. Go to REQ when stall = 0, otherwise stay.
  - REQ: if_req = 1, if_addr = pc.
    - Without if_ack: stay in REQ with if_addr held stable; stall cannot withdraw an issued request.
    - With if_ack: pc updates; next state is REQ if stall = 0, else IDLE.
- Redirect selection, priority exc > br > jr > j; only the highest valid source is taken each cycle.
- Redirect in BOOT or IDLE: applied to pc immediately, even while stall = 1. Redirect sources are single-cycle pulses and must never be dropped.
- Redirect in REQ without ack: latched into pend_target and pend_valid.
  - A newer redirect overwrites the pending one.
  - Exception: a non-exception redirect never overwrites a pending exception.
- Ack cycle, next-pc selection:
  - pc <= this-cycle redirect if present (same pending-exception rule applies), else pend_target if pend_valid, else pc + 4.
  - pend_valid clears.
- Discard and output:
  - inst_valid = if_req & if_ack & !(pend_valid | any redirect this cycle); combinational.
  - inst_pc = if_addr.
- Zero-wait memory (if_ack tied 1, no stall) yields one fetch per cycle at consecutive pc + 4.
- Alignment check: if the selected target has [1:0] != 0:
  - pc (or pend_target) <= EXC_VEC instead of the target.
  - align_err pulses for 1 cycle, registered.
  - bad_vaddr <= target.
  - The check applies to exc_target too.
- Arithmetic: pc + 4 wraps modulo 2^ADDR_W with no flag.
- Reset mid-fetch: if_req drops asynchronously; any pending redirect is lost.

Test Plan:
- Reset release, if_ack = 1, stall = 0 -> BOOT 1 cycle, then if_addr 80000000, 80000004, 80000008 on consecutive cycles, each with inst_valid = 1.
- if_ack delayed 3 cycles on 80000004 while br_valid pulses (br_target 80000100) in cycle 1 -> if_addr held at 80000004; on ack inst_valid = 0; next if_addr = 80000100.
- During an outstanding fetch, exc_valid (target 80000380) then j_valid (80000200) -> next fetch is 80000380. Repeat in reverse order -> 80000380 (exc overrides the pending jump).
- Same-cycle br_valid (80000040) and jr_valid (80000080) in IDLE with stall = 1 -> pc = 80000040 while no request is issued; fetch of 80000040 starts the cycle after stall drops.
- jr_valid with jr_target 80000102 -> align_err = 1 for one cycle, bad_vaddr = 80000102, next fetch address 80000380.
- Set RESET_VEC = FFFFFFFC, zero-wait fetch -> if_addr sequence FFFFFFFC, 00000000; assert rst mid-REQ -> if_req = 0 immediately and pc = RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch sequencer with prioritised redirects.
// Latency: if_addr is the registered pc; inst_valid is combinational in the ack cycle.
// Backpressure: if_req/if_addr hold until if_ack; stall only gates issue of a new fetch.
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h80000000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h80000380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              j_valid,
  input  logic [ADDR_W-1:0] j_target,
  output logic              if_req,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              if_ack,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              align_err,
  output logic [ADDR_W-1:0] bad_vaddr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_is_exc_q, pend_is_exc_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              align_err_q, align_err_d;
  logic [ADDR_W-1:0] bad_vaddr_q, bad_vaddr_d;

  logic              redir_vld;
  logic              redir_exc;
  logic              redir_misaligned;
  logic              redir_take;
  logic [ADDR_W-1:0] redir_raw;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(4);

  // Pick the highest-priority redirect and replace misaligned targets with the fault vector.
  always_comb begin
    redir_vld = exc_valid | br_valid | jr_valid | j_valid;
    redir_exc = exc_valid;
    redir_raw = j_target;
    if (exc_valid) begin
      redir_raw = exc_target;
    end else if (br_valid) begin
      redir_raw = br_target;
    end else if (jr_valid) begin
      redir_raw = jr_target;
    end
    redir_misaligned = redir_vld && (redir_raw[1:0] != 2'b00);
    redir_target     = redir_misaligned ? EXC_VEC : redir_raw;
    // An alignment fault is exception class; a pending exception shields against anything lower.
    redir_take = redir_vld &&
                 !(pend_valid_q && pend_is_exc_q && !(redir_exc || redir_misaligned));
  end

  // Next-state, next-pc and pending-redirect bookkeeping.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_is_exc_d = pend_is_exc_q;
    pend_target_d = pend_target_q;
    align_err_d   = 1'b0;
    bad_vaddr_d   = bad_vaddr_q;

    if (redir_take && redir_misaligned) begin
      align_err_d = 1'b1;
      bad_vaddr_d = redir_raw;
    end

    case (state_q)
      BOOT: begin
        state_d = IDLE;
        if (redir_take) pc_d = redir_target;
      end
      IDLE: begin
        if (!stall) state_d = REQ;
        if (redir_take) pc_d = redir_target;
      end
      REQ: begin
        if (if_ack) begin
          state_d       = stall ? IDLE : REQ;
          pend_valid_d  = 1'b0;
          pend_is_exc_d = 1'b0;
          if (redir_take) begin
            pc_d = redir_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = pc_inc;
          end
        end else if (redir_take) begin
          // Fetch still outstanding: park the redirect until the ack arrives.
          pend_valid_d  = 1'b1;
          pend_target_d = redir_target;
          pend_is_exc_d = redir_exc || redir_misaligned;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_is_exc_q <= 1'b0;
      pend_target_q <= '0;
      align_err_q   <= 1'b0;
      bad_vaddr_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_is_exc_q <= pend_is_exc_d;
      pend_target_q <= pend_target_d;
      align_err_q   <= align_err_d;
      bad_vaddr_q   <= bad_vaddr_d;
    end
  end

  assign if_req     = (state_q == REQ);
  assign if_addr    = pc_q;
  assign inst_pc    = pc_q;
  assign pc_plus4   = pc_inc;
  assign inst_valid = if_req && if_ack && !(pend_valid_q || redir_vld);
  assign align_err  = align_err_q;
  assign bad_vaddr  = bad_vaddr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized redirect/ack/stall traffic,
// checked every cycle against a behavioural model of fetch phase, pc and pending redirect.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h80000000;
  localparam logic [31:0] EV = 32'h80000380;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0, if_ack = 1'b0;
  logic        exc_valid = 1'b0, br_valid = 1'b0, jr_valid = 1'b0, j_valid = 1'b0;
  logic [31:0] exc_target = '0, br_target = '0, jr_target = '0, j_target = '0;
  logic        if_req, inst_valid, align_err;
  logic [31:0] if_addr, inst_pc, pc_plus4, bad_vaddr;

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_VEC(RV), .EXC_VEC(EV)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .br_valid(br_valid), .br_target(br_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .j_valid(j_valid), .j_target(j_target),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .align_err(align_err), .bad_vaddr(bad_vaddr)
  );

  // Second instance with a reset vector at the top of the address space.
  logic        rst2 = 1'b1;
  logic        zero_b = 1'b0, ack2 = 1'b1;
  logic [31:0] zero_w = '0;
  logic        if_req2, inst_valid2, align_err2;
  logic [31:0] if_addr2, inst_pc2, pc_plus4_2, bad_vaddr2;

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_VEC(32'hFFFFFFFC), .EXC_VEC(EV)) dut2 (
    .clk(clk), .rst(rst2), .stall(zero_b),
    .exc_valid(zero_b), .exc_target(zero_w),
    .br_valid(zero_b), .br_target(zero_w),
    .jr_valid(zero_b), .jr_target(zero_w),
    .j_valid(zero_b), .j_target(zero_w),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(ack2),
    .inst_valid(inst_valid2), .inst_pc(inst_pc2), .pc_plus4(pc_plus4_2),
    .align_err(align_err2), .bad_vaddr(bad_vaddr2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_fetching: a fetch is outstanding; m_waking: the post-reset dead cycle.
  bit          m_waking, m_fetching, m_pend, m_pend_exc, m_aerr;
  logic [31:0] m_pc, m_pend_tgt, m_bad;
  bit          r_any, r_fault, r_exc_class, r_take, e_ivalid;
  logic [31:0] r_addr, r_dest;

  task automatic model_reset();
    m_waking = 1; m_fetching = 0; m_pend = 0; m_pend_exc = 0; m_aerr = 0;
    m_pc = RV; m_pend_tgt = '0; m_bad = '0;
  endtask

  initial model_reset();

  // Compare DUT against the model, then advance the model across the coming clock edge.
  initial forever begin
    @(negedge clk); #3;
    if (rst) begin
      check("rst_if_req", {31'd0, if_req}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_if_addr", if_addr, RV);
      check("rst_align_err", {31'd0, align_err}, 32'd0);
      check("rst_bad_vaddr", bad_vaddr, 32'd0);
      model_reset();
    end else begin
      r_any = exc_valid || br_valid || jr_valid || j_valid;
      r_addr = exc_valid ? exc_target : br_valid ? br_target : jr_valid ? jr_target : j_target;
      r_fault = r_any && (r_addr % 4 != 0);
      r_dest = r_fault ? EV : r_addr;
      r_exc_class = exc_valid || r_fault;
      r_take = r_any && !(m_pend && m_pend_exc && !r_exc_class);
      e_ivalid = m_fetching && if_ack && !(m_pend || r_any);

      check("if_req", {31'd0, if_req}, {31'd0, m_fetching});
      check("if_addr", if_addr, m_pc);
      check("inst_pc", inst_pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("inst_valid", {31'd0, inst_valid}, {31'd0, e_ivalid});
      check("align_err", {31'd0, align_err}, {31'd0, m_aerr});
      check("bad_vaddr", bad_vaddr, m_bad);

      m_aerr = r_take && r_fault;
      if (r_take && r_fault) m_bad = r_addr;
      if (!m_fetching) begin
        if (r_take) m_pc = r_dest;
        if (m_waking) m_waking = 0;
        else if (!stall) m_fetching = 1;
      end else if (if_ack) begin
        m_pc = r_take ? r_dest : (m_pend ? m_pend_tgt : m_pc + 32'd4);
        m_pend = 0; m_pend_exc = 0;
        m_fetching = !stall;
      end else if (r_take) begin
        m_pend = 1; m_pend_tgt = r_dest; m_pend_exc = r_exc_class;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    exc_valid = 0; br_valid = 0; jr_valid = 0; j_valid = 0;
  endtask

  task automatic do_reset(input logic stall_v);
    step();
    rst = 1; clr(); if_ack = 0; stall = stall_v;
    step(); step();
    rst = 0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (!if_req && n < 20) begin step(); n++; end
    check(name, {31'd0, if_req}, 32'd1);
  endtask

  function automatic logic [31:0] rtgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 5) != 0) t[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) t = EV;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Zero-wait fetch after reset.
    do_reset(0);
    if_ack = 1;
    wait_req("t1_req_timeout", n);
    #1;
    check("t1_dead_cycles", n, 32'd2);
    check("t1_addr0", if_addr, 32'h80000000);
    check("t1_iv0", {31'd0, inst_valid}, 32'd1);
    step(); #1;
    check("t1_addr1", if_addr, 32'h80000004);
    check("t1_iv1", {31'd0, inst_valid}, 32'd1);
    step(); #1;
    check("t1_addr2", if_addr, 32'h80000008);
    check("t1_iv2", {31'd0, inst_valid}, 32'd1);

    // Wait states with a branch arriving during the outstanding fetch.
    do_reset(0);
    wait_req("t2_req_timeout", n);
    if_ack = 1;
    step(); if_ack = 0; br_valid = 1; br_target = 32'h80000100; #1;
    check("t2_addr_w1", if_addr, 32'h80000004);
    step(); clr(); #1;
    check("t2_addr_w2", if_addr, 32'h80000004);
    step(); #1;
    check("t2_addr_w3", if_addr, 32'h80000004);
    step(); if_ack = 1; #1;
    check("t2_ack_addr", if_addr, 32'h80000004);
    check("t2_ack_discard", {31'd0, inst_valid}, 32'd0);
    step(); if_ack = 0; #1;
    check("t2_redirected", if_addr, 32'h80000100);

    // Exception then jump while a fetch is outstanding.
    do_reset(0);
    wait_req("t3_req_timeout", n);
    exc_valid = 1; exc_target = 32'h80000380;
    step(); clr(); j_valid = 1; j_target = 32'h80000200;
    step(); clr(); if_ack = 1; #1;
    check("t3_discard", {31'd0, inst_valid}, 32'd0);
    step(); if_ack = 0; #1;
    check("t3_exc_then_j", if_addr, 32'h80000380);

    // Jump then exception: the exception wins.
    do_reset(0);
    wait_req("t3b_req_timeout", n);
    j_valid = 1; j_target = 32'h80000200;
    step(); clr(); exc_valid = 1; exc_target = 32'h80000380;
    step(); clr(); if_ack = 1;
    step(); if_ack = 0; #1;
    check("t3_j_then_exc", if_addr, 32'h80000380);

    // Simultaneous branch and jump-register in IDLE under stall.
    do_reset(1);
    if_ack = 1;
    step();
    br_valid = 1; br_target = 32'h80000040; jr_valid = 1; jr_target = 32'h80000080;
    step(); clr(); #1;
    check("t4_no_req", {31'd0, if_req}, 32'd0);
    check("t4_pc_br", if_addr, 32'h80000040);
    step(); #1;
    check("t4_still_idle", {31'd0, if_req}, 32'd0);
    stall = 0;
    step(); #1;
    check("t4_req_after_stall", {31'd0, if_req}, 32'd1);
    check("t4_req_addr", if_addr, 32'h80000040);

    // Misaligned jump-register target.
    do_reset(0);
    if_ack = 1;
    wait_req("t5_req_timeout", n);
    jr_valid = 1; jr_target = 32'h80000102; #1;
    check("t5_discard", {31'd0, inst_valid}, 32'd0);
    step(); clr(); #1;
    check("t5_align_err", {31'd0, align_err}, 32'd1);
    check("t5_bad_vaddr", bad_vaddr, 32'h80000102);
    check("t5_exc_fetch", if_addr, 32'h80000380);
    step(); #1;
    check("t5_align_pulse", {31'd0, align_err}, 32'd0);
    check("t5_bad_hold", bad_vaddr, 32'h80000102);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if_ack = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      exc_valid = ($urandom_range(0, 15) == 0); exc_target = rtgt();
      br_valid  = ($urandom_range(0, 7) == 0);  br_target  = rtgt();
      jr_valid  = ($urandom_range(0, 9) == 0);  jr_target  = rtgt();
      j_valid   = ($urandom_range(0, 9) == 0);  j_target   = rtgt();
    end
    step(); clr(); rst = 0;

    // Wrap at the top of the address space and asynchronous reset mid-fetch.
    step(); rst2 = 0;
    n = 0;
    while (!if_req2 && n < 20) begin step(); n++; end
    check("t6_req_timeout", {31'd0, if_req2}, 32'd1);
    #1;
    check("t6_addr_top", if_addr2, 32'hFFFFFFFC);
    step(); #1;
    check("t6_addr_wrap", if_addr2, 32'h00000000);
    step(); #2;
    rst2 = 1; #1;
    check("t6_async_req", {31'd0, if_req2}, 32'd0);
    check("t6_async_iv", {31'd0, inst_valid2}, 32'd0);
    check("t6_async_pc", if_addr2, 32'hFFFFFFFC);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
